// File: rtl/seg7_display_ctrl_mc.sv
// ---------------------------------------------------------------------------
// seg7_display_ctrl_mc
// Multi-digit seven-segment display controller with an Avalon-MM slave
// register interface. It provides hex decode, per-digit enable and blink,
// and PWM brightness control. All segment outputs are registered and
// active-low.
//
// Ports
//   clk            : single rising-edge clock
//   reset          : synchronous, active-high reset
//   avs_address    : register word address (0..15)
//   avs_write      : write strobe, one cycle per access
//   avs_writedata  : write data
//   avs_read       : read strobe, one cycle per access
//   avs_readdata   : read data, valid the cycle after the strobe, held
//                    until the next read
//   seg_writedata  : segment outputs, digit i at [8i+7:8i]
//                    (bit0 = a .. bit6 = g, bit7 = DP), active-low
// ---------------------------------------------------------------------------
module seg7_display_ctrl_mc #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              avs_address,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    input  logic                    avs_read,
    output logic [31:0]             avs_readdata,
    output logic [8*NUM_DIGITS-1:0] seg_writedata
);

    localparam int              BW        = $clog2(BLINK_DIV);
    localparam logic [BW-1:0]   CNT_MAX   = BW'(BLINK_DIV - 1);
    // Bits of the 8-bit enable/blink masks that correspond to real digits.
    localparam logic [7:0]      IMPL_MASK = 8'((16'd1 << NUM_DIGITS) - 16'd1);
    localparam logic [3:0]      ND4       = 4'(NUM_DIGITS);

    // Register state
    logic [8:0]                digit_q [NUM_DIGITS];
    logic                      hex_q;
    logic [7:0]                en_q;
    logic [7:0]                blink_q;
    logic [3:0]                bright_q;
    logic                      phase_q;
    logic [BW-1:0]             bcnt_q;
    logic [3:0]                pwm_q;
    logic [31:0]               rdata_q;
    logic [8*NUM_DIGITS-1:0]   seg_q;

    // Next-state / combinational values
    logic [31:0]               rdata_d;
    logic [8*NUM_DIGITS-1:0]   seg_d;
    logic                      pwm_on_d;

    // Writedata bits that no register implements.
    logic                      unused_wd_bits;
    assign unused_wd_bits = ^avs_writedata[31:28];

    // Active-low a..g pattern for a hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] r;
        case (n)
            4'h0:    r = 7'h40;
            4'h1:    r = 7'h79;
            4'h2:    r = 7'h24;
            4'h3:    r = 7'h30;
            4'h4:    r = 7'h19;
            4'h5:    r = 7'h12;
            4'h6:    r = 7'h02;
            4'h7:    r = 7'h78;
            4'h8:    r = 7'h00;
            4'h9:    r = 7'h10;
            4'hA:    r = 7'h08;
            4'hB:    r = 7'h03;
            4'hC:    r = 7'h46;
            4'hD:    r = 7'h21;
            4'hE:    r = 7'h06;
            4'hF:    r = 7'h0E;
            default: r = 7'h7F;
        endcase
        return r;
    endfunction

    // Full active-low pattern (incl. DP) for one digit register.
    function automatic logic [7:0] pattern(input logic [8:0] d, input logic hex);
        logic [7:0] v;
        logic       dp;
        v  = d[7:0];
        dp = d[8];
        if (hex) begin
            return {~dp, hex7(v[3:0])};
        end else begin
            // Raw value is active-high; DP lights from either value[7] or DP.
            return {~(v[7] | dp), ~v[6:0]};
        end
    endfunction

    // Read mux: digit registers, CTRL, STATUS; everything else reads 0.
    always_comb begin
        rdata_d = 32'd0;
        case (avs_address)
            4'd8:    rdata_d = {4'd0, bright_q, blink_q, en_q, 7'd0, hex_q};
            4'd9:    rdata_d = {20'd0, ND4, 7'd0, phase_q};
            default: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    rdata_d = rdata_d |
                              ((avs_address == 4'(i)) ? {23'd0, digit_q[i]} : 32'd0);
                end
            end
        endcase
    end

    // Segment output next-state: pattern gated by enable, PWM and blink.
    always_comb begin
        seg_d    = '1;
        pwm_on_d = (pwm_q <= bright_q);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_d[8*i +: 8] = (en_q[i] & pwm_on_d & ~(blink_q[i] & ~phase_q))
                              ? pattern(digit_q[i], hex_q) : 8'hFF;
        end
    end

    // Digit value registers; writes to unimplemented digits are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= 9'd0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (avs_write && (avs_address == 4'(i))) begin
                    digit_q[i] <= avs_writedata[8:0];
                end
            end
        end
    end

    // CTRL register; mask bits beyond NUM_DIGITS are forced to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q    <= 1'b1;
            en_q     <= IMPL_MASK;
            blink_q  <= 8'd0;
            bright_q <= 4'hF;
        end else if (avs_write && (avs_address == 4'd8)) begin
            hex_q    <= avs_writedata[0];
            en_q     <= avs_writedata[15:8] & IMPL_MASK;
            blink_q  <= avs_writedata[23:16] & IMPL_MASK;
            bright_q <= avs_writedata[27:24];
        end
    end

    // Free-running blink divider and PWM counter, independent of the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
            pwm_q   <= 4'd0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
            if (bcnt_q == CNT_MAX) begin
                bcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                bcnt_q  <= bcnt_q + BW'(1);
            end
        end
    end

    // Read data capture (sees pre-write values) and registered segment outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'd0;
            seg_q   <= '1;
        end else begin
            if (avs_read) begin
                rdata_q <= rdata_d;
            end
            seg_q <= seg_d;
        end
    end

    assign avs_readdata  = rdata_q;
    assign seg_writedata = seg_q;

endmodule

// File: tb/tb_seg7_display_ctrl_mc.sv
module tb_seg7_display_ctrl_mc;

    localparam int ND = 6;
    localparam int BD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  addr;
    logic        wr;
    logic        rd;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [47:0] seg;

    always #5 clk = ~clk;

    seg7_display_ctrl_mc #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (addr),
        .avs_write     (wr),
        .avs_writedata (wd),
        .avs_read      (rd),
        .avs_readdata  (rdata),
        .seg_writedata (seg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents plus time since reset release.
    logic [8:0]  m_dig [ND];
    logic        m_hex;
    logic [7:0]  m_en;
    logic [7:0]  m_bl;
    logic [3:0]  m_b;
    logic [31:0] m_rd;
    int          t;
    logic [47:0] exp_seg;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Blink phase after tt edges: starts at 1, flips every BD edges.
    function automatic logic m_phase(input int tt);
        return ((tt / BD) % 2) == 0;
    endfunction

    function automatic logic [47:0] m_seg();
        logic [47:0] r;
        logic [7:0]  v, h, pat;
        logic        dp, lit;
        for (int i = 0; i < ND; i++) begin
            v  = m_dig[i][7:0];
            dp = m_dig[i][8];
            h  = hex_tab[v[3:0]];
            pat = m_hex ? {~dp, h[6:0]} : {~(v[7] | dp), ~v[6:0]};
            lit = m_en[i] && ((t % 16) <= int'(m_b)) && !(m_bl[i] && !m_phase(t));
            r[8*i +: 8] = lit ? pat : 8'hFF;
        end
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (int'(a) < ND)  return {23'd0, m_dig[a]};
        else if (a == 4'd8) return {4'd0, m_b, m_bl, m_en, 7'd0, m_hex};
        else if (a == 4'd9) return {20'd0, 4'd6, 7'd0, m_phase(t)};
        else return 32'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ND; i++) m_dig[i] = 9'd0;
        m_hex = 1'b1;
        m_en  = 8'h3F;
        m_bl  = 8'h00;
        m_b   = 4'hF;
        m_rd  = 32'd0;
        t     = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // One clock: model advances with the same inputs, outputs sampled #1 later.
    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            m_reset();
            exp_seg = 48'hFFFF_FFFF_FFFF;
        end else begin
            exp_seg = m_seg();
            if (rd) m_rd = m_read(addr);
            if (wr) begin
                if (int'(addr) < ND) m_dig[addr] = wd[8:0];
                else if (addr == 4'd8) begin
                    m_hex = wd[0];
                    m_en  = wd[15:8] & 8'h3F;
                    m_bl  = wd[23:16] & 8'h3F;
                    m_b   = wd[27:24];
                end
            end
            t++;
        end
        #1;
        check("seg", {16'd0, seg}, {16'd0, exp_seg});
        check("rdata", {32'd0, rdata}, {32'd0, m_rd});
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        addr = a; wd = d; wr = 1'b1;
        cycle();
    endtask

    task automatic bus_read(input logic [3:0] a);
        addr = a; rd = 1'b1;
        cycle();
    endtask

    int lit_cnt;

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = 4'd0; wd = 32'd0;
        m_reset();

        // Reset held for 3 cycles
        repeat (3) begin
            cycle();
            check("rst_blank", {16'd0, seg}, {16'd0, 48'hFFFF_FFFF_FFFF});
        end
        reset = 1'b0;
        cycle();
        check("rst_c0", {16'd0, seg}, {16'd0, 48'hC0C0_C0C0_C0C0});
        bus_read(4'd8);
        check("rst_ctrl", {32'd0, rdata}, {32'd0, 32'h0F00_3F01});
        bus_read(4'd9);
        check("status", {32'd0, rdata[11:8]}, 64'd6);

        // Hex decode with DP
        bus_write(4'd2, 32'h0000_010A);
        cycle();
        check("hexA_dp", {56'd0, seg[23:16]}, {56'd0, 8'h08});
        check("hex_others", {16'd0, seg[47:24], seg[15:0]}, {16'd0, 24'hC0C0C0, 16'hC0C0});

        // Raw mode
        bus_write(4'd8, 32'h0F00_3F00);
        bus_write(4'd0, 32'h0000_0049);
        cycle();
        check("raw", {56'd0, seg[7:0]}, {56'd0, 8'hB6});

        // Unimplemented digit address and same-cycle read/write
        bus_write(4'd7, 32'h0000_01FF);
        bus_read(4'd7);
        check("addr7", {32'd0, rdata}, 64'd0);
        bus_write(4'd1, 32'h0000_0055);
        addr = 4'd1; wd = 32'h0000_00AA; wr = 1'b1; rd = 1'b1;
        cycle();
        check("rw_old", {32'd0, rdata}, {32'd0, 32'h55});
        bus_read(4'd1);
        check("rw_new", {32'd0, rdata}, {32'd0, 32'hAA});

        // Blink mask 0x01 with digit 0 disabled, then enabled
        bus_write(4'd8, 32'h0F01_3E00);
        repeat (8) cycle();
        bus_write(4'd8, 32'h0F01_3F00);
        for (int k = 0; k < 16; k++) begin
            addr = 4'd9; rd = 1'b1;
            cycle();
        end

        // PWM brightness 3: digit 1 lit on exactly 4 of 16 cycles
        bus_write(4'd8, 32'h0300_3F00);
        lit_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (seg[15:8] != 8'hFF) lit_cnt++;
        end
        check("pwm_duty", 64'(lit_cnt), 64'd4);

        // Reset during blink-off phase
        bus_write(4'd8, 32'h0F01_3F00);
        for (int k = 0; k < 10 && m_phase(t); k++) cycle();
        check("in_blink_off", {63'd0, m_phase(t)}, 64'd0);
        reset = 1'b1;
        cycle();
        check("mid_rst_blank", {16'd0, seg}, {16'd0, 48'hFFFF_FFFF_FFFF});
        reset = 1'b0;
        cycle();
        check("post_rst_c0", {16'd0, seg}, {16'd0, 48'hC0C0_C0C0_C0C0});

        // Randomized bus traffic against the model
        for (int k = 0; k < 400; k++) begin
            addr  = 4'($urandom_range(0, 15));
            wr    = ($urandom_range(0, 2) == 0);
            rd    = ($urandom_range(0, 1) == 0);
            wd    = $urandom;
            reset = ($urandom_range(0, 60) == 0);
            cycle();
            reset = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
